// File: rtl/store_queue_pkg.sv
// Shared definitions for the M-stage store queue: default depth and entry layout.
// An entry keeps only the word address; byte lanes are carried by byteen.
package store_queue_pkg;

    localparam int SQ_DEPTH = 4;
    localparam int ADDR_W   = 30;
    localparam int BE_W     = 4;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   byteen;
        logic [DATA_W-1:0] wdata;
    } sq_entry_t;

    // Rebuild a word-aligned byte address from a stored word address.
    function automatic logic [31:0] word_to_byte_addr(input logic [ADDR_W-1:0] waddr);
        return {waddr, 2'b00};
    endfunction

endpackage

// File: rtl/store_queue_ptr_ctrl.sv
// Read/write pointers and occupancy count for the store queue.
// push/pop are requests; they are gated internally by full/empty.
module sq_ptr_ctrl
    import store_queue_pkg::*;
#(
    parameter  int DEPTH = SQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_ptr_o = rd_ptr_q;
    assign wr_ptr_o = wr_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/store_queue.sv
// In-order store buffer between M-stage store formatting and the data-memory port.
// Handshake: a transfer happens on a rising edge where valid && ready; payload holds while valid && !ready.
module store_queue
    import store_queue_pkg::*;
#(
    parameter  int DEPTH = SQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [3:0]       st_byteen,
    input  logic [31:0]      st_wdata,
    output logic             st_ready,
    input  logic             ld_check,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    output logic             m_valid,
    output logic [31:0]      m_addr,
    output logic [3:0]       m_byteen,
    output logic [31:0]      m_wdata,
    input  logic             m_ready,
    output logic [CNT_W-1:0] sq_count,
    output logic             sq_empty
);

    sq_entry_t        entries_q [DEPTH];
    sq_entry_t        entries_d [DEPTH];
    sq_entry_t        head;
    sq_entry_t        new_entry;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push_req;
    logic             enq;
    logic [DEPTH-1:0] slot_valid;
    logic             addr_hit;
    logic             unused_addr_lsbs;

    // Zero-byteen stores are accepted on the handshake but never occupy a slot.
    assign push_req = st_valid && (st_byteen != '0);
    assign enq      = push_req && !full;

    sq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_i   (push_req),
        .pop_i    (m_ready),
        .rd_ptr_o (rd_ptr),
        .wr_ptr_o (wr_ptr),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    assign new_entry = '{addr: st_addr[31:2], byteen: st_byteen, wdata: st_wdata};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (enq) begin
            entries_d[wr_ptr] = new_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // A slot is live when its distance from the head (mod DEPTH) is below count.
    always_comb begin
        slot_valid = '0;
        addr_hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
            if (slot_valid[i] && (entries_q[i].addr == ld_addr[31:2])) begin
                addr_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_check && addr_hit;

    assign head     = entries_q[rd_ptr];
    assign m_valid  = !empty;
    assign m_addr   = word_to_byte_addr(head.addr);
    assign m_byteen = head.byteen;
    assign m_wdata  = head.wdata;

    assign st_ready = !full;
    assign sq_count = count;
    assign sq_empty = empty;

    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed scenarios plus a scoreboard
// that tracks expected queue contents and checks every drained entry in order.
module tb_store_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset_n;
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [3:0]       st_byteen;
    logic [31:0]      st_wdata;
    logic             st_ready;
    logic             ld_check;
    logic [31:0]      ld_addr;
    logic             ld_hazard;
    logic             m_valid;
    logic [31:0]      m_addr;
    logic [3:0]       m_byteen;
    logic [31:0]      m_wdata;
    logic             m_ready;
    logic [CNT_W-1:0] sq_count;
    logic             sq_empty;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [65:0] exp_q[$];
    int          mdl_count = 0;

    store_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_byteen (st_byteen),
        .st_wdata  (st_wdata),
        .st_ready  (st_ready),
        .ld_check  (ld_check),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_byteen  (m_byteen),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .sq_count  (sq_count),
        .sq_empty  (sq_empty)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: model occupancy, check flags each cycle and head payload against exp_q.
    always @(negedge clk) begin
        logic acc;
        logic deq;
        if (reset_n) begin
            check_cnt++;
            if (st_ready !== (mdl_count != DEPTH)) $display("FAIL sb_st_ready: got %b want %b", st_ready, (mdl_count != DEPTH));
            else pass_cnt++;
            check_cnt++;
            if (m_valid !== (mdl_count != 0)) $display("FAIL sb_m_valid: got %b want %b", m_valid, (mdl_count != 0));
            else pass_cnt++;
            check_cnt++;
            if (sq_count !== CNT_W'(mdl_count)) $display("FAIL sb_count: got %0d want %0d", sq_count, mdl_count);
            else pass_cnt++;
            check_cnt++;
            if (sq_empty !== (mdl_count == 0)) $display("FAIL sb_empty: got %b want %b", sq_empty, (mdl_count == 0));
            else pass_cnt++;
            if (mdl_count != 0 && exp_q.size() != 0) begin
                check_cnt++;
                if ({m_addr[31:2], m_byteen, m_wdata} !== exp_q[0] || m_addr[1:0] !== 2'b00)
                    $display("FAIL sb_head: got %h/%h/%h want %h", m_addr, m_byteen, m_wdata, exp_q[0]);
                else pass_cnt++;
            end
            acc = st_valid && (mdl_count != DEPTH);
            deq = m_ready && (mdl_count != 0);
            if (deq) begin
                void'(exp_q.pop_front());
                mdl_count--;
            end
            if (acc && st_byteen != 4'b0000) begin
                exp_q.push_back({st_addr[31:2], st_byteen, st_wdata});
                mdl_count++;
            end
        end
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid  = 1'b0;
        st_addr   = '0;
        st_byteen = '0;
        st_wdata  = '0;
        ld_check  = 1'b0;
        ld_addr   = '0;
        m_ready   = 1'b0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        st_valid  = 1'b1;
        st_addr   = a;
        st_byteen = be;
        st_wdata  = d;
    endtask

    task automatic drain();
        int n;
        m_ready = 1'b1;
        n = 0;
        while (!sq_empty && n < 20) begin
            cycle();
            n++;
        end
        m_ready = 1'b0;
        check_cnt++;
        if (sq_empty !== 1'b1) $display("FAIL drain_timeout: empty=%b after %0d cycles", sq_empty, n);
        else pass_cnt++;
        check_cnt++;
        if (exp_q.size() != 0) $display("FAIL drain_leftover: %0d expected entries never drained, want 0", exp_q.size());
        else pass_cnt++;
    endtask

    // Scenarios
    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        exp_q.delete();
        mdl_count = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        ld_check = 1'b1;
        cycle();
        check_cnt++;
        if (st_ready !== 1'b1) $display("FAIL rst_st_ready: got %b want 1", st_ready); else pass_cnt++;
        check_cnt++;
        if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else pass_cnt++;
        check_cnt++;
        if (m_addr !== 32'h0 || m_byteen !== 4'h0 || m_wdata !== 32'h0)
            $display("FAIL rst_payload: got %h/%h/%h want 0/0/0", m_addr, m_byteen, m_wdata);
        else pass_cnt++;
        check_cnt++;
        if (sq_count !== '0 || sq_empty !== 1'b1) $display("FAIL rst_count: got %0d/%b want 0/1", sq_count, sq_empty); else pass_cnt++;
        check_cnt++;
        if (ld_hazard !== 1'b0) $display("FAIL rst_hazard: got %b want 0", ld_hazard); else pass_cnt++;
        ld_check = 1'b0;
    endtask

    task automatic test_single();
        m_ready = 1'b0;
        drive_store(32'h0000_1006, 4'b0100, 32'h00AB_0000);
        cycle();
        st_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (m_valid !== 1'b1 || m_addr !== 32'h0000_1004 || m_byteen !== 4'b0100 || m_wdata !== 32'h00AB_0000)
                $display("FAIL single_hold%0d: got %b/%h/%h/%h want 1/00001004/4/00ab0000", i, m_valid, m_addr, m_byteen, m_wdata);
            else pass_cnt++;
            if (i < 3) cycle();
        end
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        check_cnt++;
        if (m_valid !== 1'b0) $display("FAIL single_drop: got %b want 0", m_valid); else pass_cnt++;
    endtask

    task automatic test_fill();
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_store({$urandom_range(0, 32'h0FFF_FFFF), 2'b00} + 32'(i), 4'($urandom_range(1, 15)), $urandom);
            cycle();
        end
        st_valid = 1'b0;
        check_cnt++;
        if (st_ready !== 1'b0 || sq_count !== CNT_W'(4)) $display("FAIL fill_full: got ready=%b count=%0d want 0/4", st_ready, sq_count);
        else pass_cnt++;
        drive_store(32'hDEAD_0000, 4'hF, 32'h1234_5678);
        m_ready = 1'b1;
        cycle();
        st_valid = 1'b0;
        m_ready  = 1'b0;
        check_cnt++;
        if (sq_count !== CNT_W'(3) || st_ready !== 1'b1) $display("FAIL fill_refuse: got count=%0d ready=%b want 3/1", sq_count, st_ready);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_store(32'(i * 4), 4'hF, $urandom);
            cycle();
            check_cnt++;
            if (sq_count !== CNT_W'(1)) $display("FAIL b2b_count%0d: got %0d want 1", i, sq_count); else pass_cnt++;
        end
        st_valid = 1'b0;
        cycle();
        m_ready = 1'b0;
        check_cnt++;
        if (sq_count !== '0) $display("FAIL b2b_final: got %0d want 0", sq_count); else pass_cnt++;
    endtask

    task automatic test_hazard();
        m_ready = 1'b0;
        drive_store(32'h0000_2000, 4'hF, 32'hCAFE_F00D);
        cycle();
        st_valid = 1'b0;
        ld_check = 1'b1;
        ld_addr  = 32'h0000_2003;
        #1;
        check_cnt++;
        if (ld_hazard !== 1'b1) $display("FAIL haz_same_word: got %b want 1", ld_hazard); else pass_cnt++;
        ld_addr = 32'h0000_2004;
        #1;
        check_cnt++;
        if (ld_hazard !== 1'b0) $display("FAIL haz_next_word: got %b want 0", ld_hazard); else pass_cnt++;
        ld_check = 1'b0;
        ld_addr  = 32'h0000_2000;
        #1;
        check_cnt++;
        if (ld_hazard !== 1'b0) $display("FAIL haz_no_check: got %b want 0", ld_hazard); else pass_cnt++;
        drain();
        ld_check = 1'b1;
        ld_addr  = 32'h0000_2003;
        #1;
        check_cnt++;
        if (ld_hazard !== 1'b0) $display("FAIL haz_after_drain: got %b want 0", ld_hazard); else pass_cnt++;
        drive_store(32'h0000_2000, 4'h1, 32'h0000_0011);
        #1;
        check_cnt++;
        if (ld_hazard !== 1'b0) $display("FAIL haz_same_cycle_enq: got %b want 0", ld_hazard); else pass_cnt++;
        cycle();
        st_valid = 1'b0;
        check_cnt++;
        if (ld_hazard !== 1'b1) $display("FAIL haz_after_enq: got %b want 1", ld_hazard); else pass_cnt++;
        ld_check = 1'b0;
        drive_store(32'h0000_3000, 4'h0, 32'hFFFF_FFFF);
        cycle();
        st_valid = 1'b0;
        check_cnt++;
        if (sq_count !== CNT_W'(1)) $display("FAIL zero_byteen: got count %0d want 1", sq_count); else pass_cnt++;
        drain();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h0000_4000 + 32'(i * 4), 4'hF, $urandom);
            cycle();
        end
        st_valid = 1'b0;
        check_cnt++;
        if (sq_count !== CNT_W'(3)) $display("FAIL mid_fill: got %0d want 3", sq_count); else pass_cnt++;
        m_ready  = 1'b1;
        ld_check = 1'b1;
        ld_addr  = 32'h0000_4000;
        #2 reset_n = 1'b0;
        exp_q.delete();
        mdl_count = 0;
        #1;
        check_cnt++;
        if (m_valid !== 1'b0 || sq_count !== '0 || st_ready !== 1'b1 || sq_empty !== 1'b1)
            $display("FAIL mid_reset: got valid=%b count=%0d ready=%b empty=%b want 0/0/1/1", m_valid, sq_count, st_ready, sq_empty);
        else pass_cnt++;
        check_cnt++;
        if (ld_hazard !== 1'b0) $display("FAIL mid_reset_hazard: got %b want 0", ld_hazard); else pass_cnt++;
        ld_check = 1'b0;
        m_ready  = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive_store(32'h0000_5009, 4'b0011, 32'h0000_BEEF);
        cycle();
        st_valid = 1'b0;
        check_cnt++;
        if (m_valid !== 1'b1 || m_addr !== 32'h0000_5008 || m_byteen !== 4'b0011 || m_wdata !== 32'h0000_BEEF)
            $display("FAIL mid_new_head: got %b/%h/%h/%h want 1/00005008/3/0000beef", m_valid, m_addr, m_byteen, m_wdata);
        else pass_cnt++;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_hazard();
        test_reset_mid();
        repeat (2) cycle();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
